// File: rtl/stim_check_pkg.sv
// Definitions shared by the stimulus engine and the checker: sc_cmd codes,
// the failure-record tag, the CHECK_FIFO entry layout and the checker FSM states.
package stim_check_pkg;

  localparam logic [4:0] SC_CMD_IDLE    = 5'd0;
  localparam logic [4:0] SC_CMD_BITMASK = 5'd1;

  // Upper nibble of every failure record in result memory.
  localparam logic [3:0] REC_TAG = 4'b0001;

  // CHECK_FIFO entry is {expected, vec_addr, orv} MSB-first; these give LSB offsets.
  function automatic int unsigned chf_orv_lsb();
    return 0;
  endfunction

  function automatic int unsigned chf_addr_lsb(input int unsigned orv_w);
    return orv_w;
  endfunction

  function automatic int unsigned chf_exp_lsb(input int unsigned orv_w,
                                              input int unsigned addr_w);
    return orv_w + addr_w;
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StPop,
    StCompare,
    StWrite
  } check_state_e;

endpackage

// File: rtl/check_if.sv
// Avalon-MM write-master bus between the checker and result memory.
interface check_if #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0]   mem_address;
  logic [DATA_WIDTH/8-1:0] mem_byteenable;
  logic                    mem_write;
  logic [DATA_WIDTH-1:0]   mem_writedata;
  logic                    mem_waitrequest;

  modport master (
    output mem_address,
    output mem_byteenable,
    output mem_write,
    output mem_writedata,
    input  mem_waitrequest
  );

  modport slave (
    input  mem_address,
    input  mem_byteenable,
    input  mem_write,
    input  mem_writedata,
    output mem_waitrequest
  );

endinterface

// File: rtl/check_logger.sv
// Serialises one 4-word failure record into Avalon writes, owns the log pointer
// and flags records dropped because the log region is full.
module check_logger
  import stim_check_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 20,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] LOG_BASE   = 20'h80000,
  parameter logic [ADDR_WIDTH-1:0] LOG_LIMIT  = 20'hFFFFC
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [4*DATA_WIDTH-1:0] record_i,
  output logic                    room_o,
  output logic                    done_o,
  output logic                    overflow_o,
  check_if.master                 mem
);

  localparam int unsigned RecWidth = 4 * DATA_WIDTH;

  // One spare bit so the pointer cannot wrap back into range past LOG_LIMIT.
  logic [ADDR_WIDTH:0]     log_ptr_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [RecWidth-1:0]     rec_q;
  logic [1:0]              word_q;
  logic                    write_q;
  logic                    ovf_q;
  logic                    clr_seen_q;
  logic                    accept;

  assign accept     = write_q & ~mem.mem_waitrequest;
  assign room_o     = (log_ptr_q <= {1'b0, LOG_LIMIT});
  assign done_o     = accept & (word_q == 2'd3);
  assign overflow_o = ovf_q;

  assign mem.mem_address    = addr_q;
  assign mem.mem_writedata  = data_q;
  assign mem.mem_write      = write_q;
  assign mem.mem_byteenable = '1;

  // Record shifter, word counter, log pointer and sticky overflow.
  always_ff @(posedge clock) begin
    if (reset) begin
      log_ptr_q  <= {1'b0, LOG_BASE};
      addr_q     <= LOG_BASE;
      data_q     <= '0;
      rec_q      <= '0;
      word_q     <= 2'd0;
      write_q    <= 1'b0;
      ovf_q      <= 1'b0;
      clr_seen_q <= 1'b0;
    end else begin
      if (start_i && !write_q) begin
        if (room_o) begin
          write_q    <= 1'b1;
          addr_q     <= log_ptr_q[ADDR_WIDTH-1:0];
          data_q     <= record_i[RecWidth-1 -: DATA_WIDTH];
          rec_q      <= record_i << DATA_WIDTH;
          word_q     <= 2'd0;
          clr_seen_q <= 1'b0;
        end else begin
          ovf_q <= 1'b1;
        end
      end else if (accept) begin
        if (word_q == 2'd3) begin
          write_q <= 1'b0;
          // A clear during the record leaves the pointer at the base.
          if (!clr_seen_q) log_ptr_q <= log_ptr_q + (ADDR_WIDTH + 1)'(4);
        end else begin
          addr_q <= addr_q + ADDR_WIDTH'(1);
          data_q <= rec_q[RecWidth-1 -: DATA_WIDTH];
          rec_q  <= rec_q << DATA_WIDTH;
          word_q <= word_q + 2'd1;
        end
      end
      if (clear_i) begin
        log_ptr_q  <= {1'b0, LOG_BASE};
        ovf_q      <= 1'b0;
        clr_seen_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/check.sv
// Checker: pops expected/actual pairs, compares them under the programmed
// bitmask, counts pass/fail and logs mismatches to result memory.
module check
  import stim_check_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 20,
  parameter int unsigned           DATA_WIDTH = 16,
  parameter int unsigned           STF_WIDTH  = 24,
  parameter int unsigned           ORV_WIDTH  = 8,
  parameter int unsigned           CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
  parameter int unsigned           SCC_WIDTH  = 5,
  parameter int unsigned           SCD_WIDTH  = 24,
  parameter int unsigned           CNT_WIDTH  = 16,
  parameter logic [ADDR_WIDTH-1:0] LOG_BASE   = 20'h80000,
  parameter logic [ADDR_WIDTH-1:0] LOG_LIMIT  = 20'hFFFFC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CHF_WIDTH-1:0] cfifo_q,
  input  logic                 cfifo_rdempty,
  output logic                 cfifo_rdreq,
  input  logic [STF_WIDTH-1:0] rfifo_q,
  input  logic                 rfifo_rdempty,
  output logic                 rfifo_rdreq,
  input  logic [SCC_WIDTH-1:0] sc_cmd,
  input  logic [SCD_WIDTH-1:0] sc_data,
  output logic                 sc_ready,
  check_if.master              mem,
  input  logic                 stats_clear,
  output logic [CNT_WIDTH-1:0] pass_count,
  output logic [CNT_WIDTH-1:0] fail_count,
  output logic                 log_overflow
);

  localparam int unsigned ExpLsb  = chf_exp_lsb(ORV_WIDTH, ADDR_WIDTH);
  localparam int unsigned AddrLsb = chf_addr_lsb(ORV_WIDTH);
  localparam int unsigned OrvLsb  = chf_orv_lsb();

  check_state_e          state_q;
  logic                  rdreq_q;
  logic [STF_WIDTH-1:0]  expected_q;
  logic [STF_WIDTH-1:0]  actual_q;
  logic [STF_WIDTH-1:0]  bitmask_q;
  logic [ADDR_WIDTH-1:0] vec_addr_q;
  logic [CNT_WIDTH-1:0]  pass_q;
  logic [CNT_WIDTH-1:0]  fail_q;
  logic                  mismatch;
  logic                  log_start;
  logic                  log_room;
  logic                  log_done;
  logic [4*DATA_WIDTH-1:0] record;
  logic                  unused_orv;

  // The or-value field is consumed by the stimulus side only.
  assign unused_orv = ^cfifo_q[OrvLsb +: ORV_WIDTH];

  assign mismatch  = |((expected_q ^ actual_q) & bitmask_q);
  assign log_start = (state_q == StCompare) & mismatch;
  assign record    = {REC_TAG, vec_addr_q, actual_q, 16'h0000};

  assign cfifo_rdreq  = rdreq_q;
  assign rfifo_rdreq  = rdreq_q;
  // Masks only change when nothing is queued, so no vector sees a mask it was not built for.
  assign sc_ready     = ~reset & (state_q == StIdle) & cfifo_rdempty;
  assign pass_count   = pass_q;
  assign fail_count   = fail_q;

  // Main FSM with registered pop strobe and capture of the popped pair.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      rdreq_q    <= 1'b0;
      expected_q <= '0;
      actual_q   <= '0;
      vec_addr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!cfifo_rdempty && !rfifo_rdempty) begin
            state_q <= StPop;
            rdreq_q <= 1'b1;
          end
        end
        StPop: begin
          rdreq_q    <= 1'b0;
          expected_q <= cfifo_q[ExpLsb +: STF_WIDTH];
          vec_addr_q <= cfifo_q[AddrLsb +: ADDR_WIDTH];
          actual_q   <= rfifo_q;
          state_q    <= StCompare;
        end
        StCompare: begin
          state_q <= (mismatch && log_room) ? StWrite : StIdle;
        end
        StWrite: begin
          if (log_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Saturating pass/fail counters; clear beats a same-cycle increment.
  always_ff @(posedge clock) begin
    if (reset || stats_clear) begin
      pass_q <= '0;
      fail_q <= '0;
    end else if (state_q == StCompare) begin
      if (mismatch) begin
        if (fail_q != '1) fail_q <= fail_q + CNT_WIDTH'(1);
      end else begin
        if (pass_q != '1) pass_q <= pass_q + CNT_WIDTH'(1);
      end
    end
  end

  // Compare mask written over the sc link; unknown commands are dropped.
  always_ff @(posedge clock) begin
    if (reset) begin
      bitmask_q <= '1;
    end else if (sc_ready && (sc_cmd == SCC_WIDTH'(SC_CMD_BITMASK))) begin
      bitmask_q <= sc_data[STF_WIDTH-1:0];
    end
  end

  check_logger #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .LOG_BASE   (LOG_BASE),
    .LOG_LIMIT  (LOG_LIMIT)
  ) u_logger (
    .clock      (clock),
    .reset      (reset),
    .clear_i    (stats_clear),
    .start_i    (log_start),
    .record_i   (record),
    .room_o     (log_room),
    .done_o     (log_done),
    .overflow_o (log_overflow),
    .mem        (mem)
  );

endmodule

// File: tb/tb_check.sv
// Directed bench for the checker: FIFO pairs are presented one at a time,
// result-memory writes are captured by a monitor and compared to hand-built records.
module tb_check;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [51:0] cfifo_q = '0;
  logic        cfifo_rdempty = 1'b1;
  logic        cfifo_rdreq;
  logic [23:0] rfifo_q = '0;
  logic        rfifo_rdempty = 1'b1;
  logic        rfifo_rdreq;
  logic [4:0]  sc_cmd = '0;
  logic [23:0] sc_data = '0;
  logic        sc_ready;
  logic        stats_clear = 1'b0;
  logic [15:0] pass_count;
  logic [15:0] fail_count;
  logic        log_overflow;

  int n_vec  = 0;
  int n_miss = 0;

  logic [19:0] wr_addr[$];
  logic [15:0] wr_data[$];

  check_if #(.ADDR_WIDTH(20), .DATA_WIDTH(16)) mem_bus ();

  check #(.LOG_LIMIT(20'h80010)) dut (
    .clock         (clock),
    .reset         (reset),
    .cfifo_q       (cfifo_q),
    .cfifo_rdempty (cfifo_rdempty),
    .cfifo_rdreq   (cfifo_rdreq),
    .rfifo_q       (rfifo_q),
    .rfifo_rdempty (rfifo_rdempty),
    .rfifo_rdreq   (rfifo_rdreq),
    .sc_cmd        (sc_cmd),
    .sc_data       (sc_data),
    .sc_ready      (sc_ready),
    .mem           (mem_bus),
    .stats_clear   (stats_clear),
    .pass_count    (pass_count),
    .fail_count    (fail_count),
    .log_overflow  (log_overflow)
  );

  always #5 clock = ~clock;

  // Capture every write the slave accepts.
  always @(posedge clock) begin
    if (mem_bus.mem_write && !mem_bus.mem_waitrequest) begin
      wr_addr.push_back(mem_bus.mem_address);
      wr_data.push_back(mem_bus.mem_writedata);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Presents one pair; returns at the negedge of the pop cycle.
  task automatic apply_vec(input logic [23:0] exp_v, input logic [19:0] addr_v,
                           input logic [23:0] act_v);
    bit seen;
    seen = 1'b0;
    cfifo_q = {exp_v, addr_v, 8'h5A};
    rfifo_q = act_v;
    cfifo_rdempty = 1'b0;
    rfifo_rdempty = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clock);
      if (cfifo_rdreq) seen = 1'b1;
    end
    if (!seen) check_val("pop_timeout", 32'(seen), 32'd1);
    else       check_val("rfifo_rdreq", 32'(rfifo_rdreq), 32'd1);
    cfifo_rdempty = 1'b1;
    rfifo_rdempty = 1'b1;
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wr_addr.size() < n && k < 80) begin
      @(negedge clock);
      k++;
    end
    if (wr_addr.size() < n) check_val("write_timeout", 32'(wr_addr.size()), 32'(n));
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!sc_ready && k < 80) begin
      @(negedge clock);
      k++;
    end
    if (!sc_ready) check_val("idle_timeout", 32'(sc_ready), 32'd1);
  endtask

  task automatic pulse_clear();
    stats_clear = 1'b1;
    tick(1);
    stats_clear = 1'b0;
  endtask

  task automatic check_record(input int base, input logic [19:0] addr,
                              input logic [63:0] rec);
    logic [63:0] r;
    r = rec;
    for (int k = 0; k < 4; k++) begin
      check_val("rec_addr", 32'(wr_addr[base+k]), 32'(addr + 20'(k)));
      check_val("rec_data", 32'(wr_data[base+k]), 32'(r[63-16*k -: 16]));
    end
  endtask

  initial begin
    int snap;
    mem_bus.mem_waitrequest = 1'b0;

    // Reset cycle
    @(negedge clock);
    check_val("rst_sc_ready", 32'(sc_ready), 32'd0);
    check_val("rst_rdreq", 32'(cfifo_rdreq), 32'd0);
    check_val("rst_mem_write", 32'(mem_bus.mem_write), 32'd0);
    tick(1);
    reset = 1'b0;
    tick(1);
    check_val("rst_addr", 32'(mem_bus.mem_address), 32'h80000);
    check_val("rst_wdata", 32'(mem_bus.mem_writedata), 32'd0);
    check_val("rst_byteen", 32'(mem_bus.mem_byteenable), 32'h3);
    check_val("rst_pass", 32'(pass_count), 32'd0);
    check_val("rst_fail", 32'(fail_count), 32'd0);
    check_val("rst_ovf", 32'(log_overflow), 32'd0);
    check_val("idle_sc_ready", 32'(sc_ready), 32'd1);

    // Matching pair under the reset mask
    apply_vec(24'hA5A5A5, 20'h0, 24'hA5A5A5);
    check_val("m_pass_T", 32'(pass_count), 32'd0);
    tick(1);
    check_val("m_rdreq_one", 32'(cfifo_rdreq), 32'd0);
    check_val("m_pass_T1", 32'(pass_count), 32'd0);
    tick(1);
    check_val("m_pass_T2", 32'(pass_count), 32'd1);
    tick(3);
    check_val("m_no_write", 32'(wr_addr.size()), 32'd0);

    // Mismatch and its record
    apply_vec(24'h000001, 20'h00123, 24'h000000);
    tick(2);
    check_val("f_write_T2", 32'(mem_bus.mem_write), 32'd1);
    check_val("f_addr_T2", 32'(mem_bus.mem_address), 32'h80000);
    wait_writes(4);
    wait_idle();
    check_val("f_fail", 32'(fail_count), 32'd1);
    check_record(0, 20'h80000, 64'h1001_2300_0000_0000);

    // Mask accepted while idle and empty
    check_val("mask_ready", 32'(sc_ready), 32'd1);
    sc_cmd = 5'd1;
    sc_data = 24'hFFFFFE;
    tick(1);
    sc_cmd = 5'd0;
    apply_vec(24'h000001, 20'h5, 24'h000000);
    tick(2);
    check_val("mask_pass", 32'(pass_count), 32'd2);
    check_val("mask_fail", 32'(fail_count), 32'd1);

    // Mask blocked while cfifo is non-empty; lone non-empty FIFO must not pop
    cfifo_q = {24'h000001, 20'h6, 8'h00};
    cfifo_rdempty = 1'b0;
    tick(1);
    check_val("blk_ready", 32'(sc_ready), 32'd0);
    sc_cmd = 5'd1;
    sc_data = 24'hFFFFFF;
    tick(3);
    check_val("blk_no_pop", 32'(cfifo_rdreq), 32'd0);
    sc_cmd = 5'd0;
    cfifo_rdempty = 1'b1;
    apply_vec(24'h000001, 20'h6, 24'h000000);
    tick(2);
    check_val("blk_mask_kept", 32'(pass_count), 32'd3);
    wait_idle();
    sc_cmd = 5'd1;
    sc_data = 24'hFFFFFF;
    tick(1);
    // An unknown command carrying an all-zero mask must be ignored
    sc_cmd = 5'd2;
    sc_data = 24'h000000;
    tick(1);
    sc_cmd = 5'd0;

    // Stalled record
    pulse_clear();
    check_val("clr_pass", 32'(pass_count), 32'd0);
    check_val("clr_fail", 32'(fail_count), 32'd0);
    wr_addr.delete();
    wr_data.delete();
    apply_vec(24'hFFFFFF, 20'h00ABC, 24'h123456);
    snap = 0;
    while (!(mem_bus.mem_write && mem_bus.mem_address == 20'h80001) && snap < 20) begin
      tick(1);
      snap++;
    end
    mem_bus.mem_waitrequest = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_val("stall_write", 32'(mem_bus.mem_write), 32'd1);
      check_val("stall_addr", 32'(mem_bus.mem_address), 32'h80001);
      check_val("stall_data", 32'(mem_bus.mem_writedata), 32'hBC12);
    end
    mem_bus.mem_waitrequest = 1'b0;
    wait_writes(4);
    wait_idle();
    check_record(0, 20'h80000, 64'h100A_BC12_3456_0000);
    apply_vec(24'h000000, 20'h1, 24'h000001);
    tick(2);
    check_val("ptr_80004", 32'(mem_bus.mem_address), 32'h80004);
    wait_writes(8);
    wait_idle();

    // Log full after five records
    pulse_clear();
    wr_addr.delete();
    wr_data.delete();
    for (int i = 0; i < 6; i++) begin
      apply_vec(24'h000000, 20'(i), 24'h000001);
      wait_idle();
    end
    check_val("ovf_writes", 32'(wr_addr.size()), 32'd20);
    if (wr_addr.size() >= 20) check_record(16, 20'h80010, 64'h1000_0400_0001_0000);
    check_val("ovf_fail", 32'(fail_count), 32'd6);
    check_val("ovf_flag", 32'(log_overflow), 32'd1);

    // Clear coinciding with a pass increment
    apply_vec(24'h000005, 20'h7, 24'h000005);
    tick(1);
    stats_clear = 1'b1;
    tick(1);
    stats_clear = 1'b0;
    check_val("clrwin_pass", 32'(pass_count), 32'd0);
    check_val("clrwin_fail", 32'(fail_count), 32'd0);
    check_val("clrwin_ovf", 32'(log_overflow), 32'd0);

    // Reset in the middle of a record
    wait_idle();
    wr_addr.delete();
    wr_data.delete();
    apply_vec(24'h000000, 20'h1, 24'h000001);
    wait_writes(4);
    wait_idle();
    check_val("pre_rst_addr", 32'(wr_addr[0]), 32'h80000);
    apply_vec(24'h000000, 20'h2, 24'h000001);
    wait_writes(6);
    reset = 1'b1;
    #1;
    check_val("rst_mid_ready", 32'(sc_ready), 32'd0);
    tick(1);
    reset = 1'b0;
    snap = wr_addr.size();
    check_val("rst_mid_write", 32'(mem_bus.mem_write), 32'd0);
    tick(5);
    check_val("rst_no_more", 32'(wr_addr.size()), 32'(snap));
    apply_vec(24'h000000, 20'h3, 24'h000001);
    tick(2);
    check_val("rst_ptr_base", 32'(mem_bus.mem_address), 32'h80000);
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
